boot_loader: RTL and testbench

Boot-time copy engine that sits directly upstream of the hummingbird core. After reset it streams LOAD_LEN bytes from the program EEPROM into the CY7C199 program RAM, one byte per fixed-length sequence. It holds the core in reset until the copy is complete, then asserts `done` and releases the core. It replaces the core's PC-driven boot copy with a dedicated sequencer that also produces a byte checksum.

---
 rtl/boot_pkg.sv | 16 +
 rtl/boot_addr_counter.sv | 34 +++
 rtl/boot_loader.sv | 145 ++++++++++++++
 tb/tb_boot_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot-time ROM-to-RAM copy engine.
package boot_pkg;

   localparam int WAIT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_LATCH = 3'd3,
      ST_WRITE = 3'd4,
      ST_NEXT  = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

endpackage

// File: rtl/boot_addr_counter.sv
// Copy address counter: clear, increment, and terminal-count flag at LOAD_LEN-1.
module boot_addr_counter
   import boot_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int LOAD_LEN = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_count,
   output logic              o_last
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_LEN - 1);

   logic [ADDR_W-1:0] r_count;

   // Saturates at the last address so a full 2^ADDR_W copy never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && !o_last) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_last  = (r_count == LAST_ADDR);

endmodule

// File: rtl/boot_loader.sv
// Boot sequencer: copies LOAD_LEN bytes EEPROM -> program RAM, sums them, then releases the core.
module boot_loader
   import boot_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int LOAD_LEN    = 4096,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reload,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_ce_bar,
   input  logic [7:0]        rom_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_data,
   output logic              ram_ce_bar,
   output logic              ram_we_bar,
   output logic              cpu_rst_bar,
   output logic              busy,
   output logic              done,
   output logic [7:0]        checksum
);

   state_t              r_state;
   state_t              w_state_next;
   logic [WAIT_W-1:0]   r_wait;
   logic                w_clr;
   logic                w_inc;
   logic                w_capture;
   logic [ADDR_W-1:0]   w_count;
   logic                w_last;

   logic [ADDR_W-1:0]   r_ram_addr;
   logic [7:0]          r_ram_data;
   logic [7:0]          r_checksum;
   logic                r_rom_ce_bar;
   logic                r_ram_ce_bar;
   logic                r_ram_we_bar;
   logic                r_cpu_rst_bar;
   logic                r_busy;
   logic                r_done;

   boot_addr_counter #(
      .ADDR_W   (ADDR_W),
      .LOAD_LEN (LOAD_LEN)
   ) u_counter (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr),
      .i_inc   (w_inc),
      .o_count (w_count),
      .o_last  (w_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_clr        = 1'b0;
      w_inc        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_clr        = 1'b1;
            w_state_next = ST_ADDR;
         end
         ST_ADDR:  w_state_next = (WAIT_CYCLES == 0) ? ST_LATCH : ST_WAIT;
         ST_WAIT:  if (r_wait <= WAIT_W'(1)) w_state_next = ST_LATCH;
         ST_LATCH: w_state_next = ST_WRITE;
         ST_WRITE: w_state_next = ST_NEXT;
         ST_NEXT: begin
            if (w_last) begin
               w_state_next = ST_DONE;
            end else begin
               w_inc        = 1'b1;
               w_state_next = ST_ADDR;
            end
         end
         ST_DONE:  if (reload) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // ROM data is taken on the edge that enters LATCH, i.e. at the end of the last wait cycle.
   assign w_capture = (w_state_next == ST_LATCH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait <= '0;
      end else if (r_state == ST_ADDR) begin
         r_wait <= WAIT_W'(WAIT_CYCLES);
      end else if (r_state == ST_WAIT) begin
         r_wait <= r_wait - 1'b1;
      end
   end

   // Strobes and status are decoded from the next state so every output comes straight off a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ram_addr    <= '0;
         r_ram_data    <= '0;
         r_checksum    <= '0;
         r_rom_ce_bar  <= 1'b1;
         r_ram_ce_bar  <= 1'b1;
         r_ram_we_bar  <= 1'b1;
         r_cpu_rst_bar <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_rom_ce_bar  <= !((w_state_next == ST_ADDR) || (w_state_next == ST_WAIT));
         r_ram_ce_bar  <= (w_state_next != ST_WRITE);
         r_ram_we_bar  <= (w_state_next != ST_WRITE);
         r_cpu_rst_bar <= (w_state_next == ST_DONE);
         r_done        <= (w_state_next == ST_DONE);
         r_busy        <= !((w_state_next == ST_IDLE) || (w_state_next == ST_DONE));
         if (r_state == ST_IDLE) begin
            r_checksum <= '0;
         end else if (w_capture) begin
            r_checksum <= r_checksum + rom_data;
         end
         if (w_capture) begin
            r_ram_data <= rom_data;
            r_ram_addr <= w_count;
         end
      end
   end

   assign rom_addr    = w_count;
   assign rom_ce_bar  = r_rom_ce_bar;
   assign ram_addr    = r_ram_addr;
   assign ram_data    = r_ram_data;
   assign ram_ce_bar  = r_ram_ce_bar;
   assign ram_we_bar  = r_ram_we_bar;
   assign cpu_rst_bar = r_cpu_rst_bar;
   assign busy        = r_busy;
   assign done        = r_done;
   assign checksum    = r_checksum;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench: three boot_loader configurations, run table, write log table, reload/reset sequences.
module tb_boot_loader;

   typedef struct {
      int         unit;
      int         cycles;
      logic [7:0] sum;
   } run_t;

   typedef struct {
      int         unit;
      int         addr;
      logic [7:0] data;
   } wr_t;

   logic       clk = 1'b0;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;

   logic       rst_u    [3];
   logic       reload_u [3];
   logic       rom_ce_u [3];
   logic       ram_ce_u [3];
   logic       we_u     [3];
   logic       cpurst_u [3];
   logic       busy_u   [3];
   logic       done_u   [3];
   logic [7:0] ram_data_u [3];
   logic [7:0] csum_u     [3];

   logic [11:0] rom_addr_a, ram_addr_a;
   logic [0:0]  rom_addr_b, ram_addr_b;
   logic [3:0]  rom_addr_c, ram_addr_c;
   logic [7:0]  rom_data_a, rom_data_b, rom_data_c;
   logic [7:0]  rom_a [4];
   logic [7:0]  rom_b [2];
   logic [7:0]  rom_c [2];
   int          cnt_c = 0;

   wr_t obs[$];
   wr_t exp_wr[19];
   run_t runs[3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Unit C ROM is only valid from the fourth cycle of an access; earlier it returns junk.
   always @(posedge clk) begin
      if (rom_ce_u[2]) cnt_c <= 0;
      else             cnt_c <= cnt_c + 1;
   end

   assign rom_data_a = rom_a[rom_addr_a[1:0]];
   assign rom_data_b = rom_b[rom_addr_b];
   assign rom_data_c = (cnt_c >= 3) ? rom_c[rom_addr_c[0]] : 8'hEE;

   boot_loader #(.ADDR_W(12), .LOAD_LEN(4), .WAIT_CYCLES(1)) u_a (
      .clk(clk), .rst(rst_u[0]), .reload(reload_u[0]),
      .rom_addr(rom_addr_a), .rom_ce_bar(rom_ce_u[0]), .rom_data(rom_data_a),
      .ram_addr(ram_addr_a), .ram_data(ram_data_u[0]), .ram_ce_bar(ram_ce_u[0]),
      .ram_we_bar(we_u[0]), .cpu_rst_bar(cpurst_u[0]), .busy(busy_u[0]),
      .done(done_u[0]), .checksum(csum_u[0]));

   boot_loader #(.ADDR_W(1), .LOAD_LEN(2), .WAIT_CYCLES(0)) u_b (
      .clk(clk), .rst(rst_u[1]), .reload(reload_u[1]),
      .rom_addr(rom_addr_b), .rom_ce_bar(rom_ce_u[1]), .rom_data(rom_data_b),
      .ram_addr(ram_addr_b), .ram_data(ram_data_u[1]), .ram_ce_bar(ram_ce_u[1]),
      .ram_we_bar(we_u[1]), .cpu_rst_bar(cpurst_u[1]), .busy(busy_u[1]),
      .done(done_u[1]), .checksum(csum_u[1]));

   boot_loader #(.ADDR_W(4), .LOAD_LEN(2), .WAIT_CYCLES(3)) u_c (
      .clk(clk), .rst(rst_u[2]), .reload(reload_u[2]),
      .rom_addr(rom_addr_c), .rom_ce_bar(rom_ce_u[2]), .rom_data(rom_data_c),
      .ram_addr(ram_addr_c), .ram_data(ram_data_u[2]), .ram_ce_bar(ram_ce_u[2]),
      .ram_we_bar(we_u[2]), .cpu_rst_bar(cpurst_u[2]), .busy(busy_u[2]),
      .done(done_u[2]), .checksum(csum_u[2]));

   function automatic void log_wr(input int u, input int a, input logic [7:0] d);
      wr_t w;
      w.unit = u;
      w.addr = a;
      w.data = d;
      obs.push_back(w);
   endfunction

   // A write is one negedge sample with both RAM strobes low; a two-cycle strobe shows up as a duplicate.
   always @(negedge clk) begin
      if (!we_u[0] && !ram_ce_u[0]) log_wr(0, int'(ram_addr_a), ram_data_u[0]);
      if (!we_u[1] && !ram_ce_u[1]) log_wr(1, int'(ram_addr_b), ram_data_u[1]);
      if (!we_u[2] && !ram_ce_u[2]) log_wr(2, int'(ram_addr_c), ram_data_u[2]);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("[TB] ok %s = 0x%0h", name, act);
      end
   endtask

   task automatic wait_done(input int u, input int start, input int exp_cyc,
                            input logic [7:0] exp_sum, input string tag);
      int n = 0;
      while (done_u[u] !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (done_u[u] !== 1'b1) begin
         chk({tag, " done timeout"}, 32'(done_u[u]), 32'd1);
      end else begin
         chk({tag, " cycles to done"}, 32'(cyc - start), 32'(exp_cyc));
         chk({tag, " checksum"}, 32'(csum_u[u]), 32'(exp_sum));
         chk({tag, " busy low"}, 32'(busy_u[u]), 32'd0);
         chk({tag, " cpu_rst_bar high"}, 32'(cpurst_u[u]), 32'd1);
      end
   endtask

   initial begin
      int start;
      int n;

      rom_a = '{8'h12, 8'h34, 8'h56, 8'h78};
      rom_b = '{8'hFF, 8'h02};
      rom_c = '{8'hA5, 8'h3C};

      runs[0] = '{0, 21, 8'h14};
      runs[1] = '{1, 9,  8'h01};
      runs[2] = '{2, 15, 8'hE1};

      exp_wr[0]  = '{0, 0, 8'h12}; exp_wr[1]  = '{0, 1, 8'h34};
      exp_wr[2]  = '{0, 2, 8'h56}; exp_wr[3]  = '{0, 3, 8'h78};
      exp_wr[4]  = '{1, 0, 8'hFF}; exp_wr[5]  = '{1, 1, 8'h02};
      exp_wr[6]  = '{2, 0, 8'hA5}; exp_wr[7]  = '{2, 1, 8'h3C};
      exp_wr[8]  = '{0, 0, 8'h12}; exp_wr[9]  = '{0, 1, 8'h34};
      exp_wr[10] = '{0, 2, 8'h56}; exp_wr[11] = '{0, 3, 8'h78};
      exp_wr[12] = '{0, 0, 8'h12}; exp_wr[13] = '{0, 1, 8'h34};
      exp_wr[14] = '{0, 2, 8'h56};
      exp_wr[15] = '{0, 0, 8'h12}; exp_wr[16] = '{0, 1, 8'h34};
      exp_wr[17] = '{0, 2, 8'h56}; exp_wr[18] = '{0, 3, 8'h78};

      for (int u = 0; u < 3; u++) begin
         rst_u[u]    = 1'b1;
         reload_u[u] = 1'b0;
      end
      repeat (2) @(negedge clk);

      chk("reset rom_addr",    32'(rom_addr_a),    32'd0);
      chk("reset ram_addr",    32'(ram_addr_a),    32'd0);
      chk("reset ram_data",    32'(ram_data_u[0]), 32'd0);
      chk("reset checksum",    32'(csum_u[0]),     32'd0);
      chk("reset rom_ce_bar",  32'(rom_ce_u[0]),   32'd1);
      chk("reset ram_ce_bar",  32'(ram_ce_u[0]),   32'd1);
      chk("reset ram_we_bar",  32'(we_u[0]),       32'd1);
      chk("reset cpu_rst_bar", 32'(cpurst_u[0]),   32'd0);
      chk("reset busy",        32'(busy_u[0]),     32'd0);
      chk("reset done",        32'(done_u[0]),     32'd0);

      // Full copy per configuration, with a reload pulse mid-copy that must be ignored.
      for (int r = 0; r < 3; r++) begin
         rst_u[runs[r].unit] = 1'b0;
         start = cyc;
         @(negedge clk);
         chk($sformatf("run%0d busy after IDLE", r), 32'(busy_u[runs[r].unit]), 32'd1);
         chk($sformatf("run%0d rom_ce_bar in ADDR", r), 32'(rom_ce_u[runs[r].unit]), 32'd0);
         @(negedge clk);
         reload_u[runs[r].unit] = 1'b1;
         @(negedge clk);
         reload_u[runs[r].unit] = 1'b0;
         chk($sformatf("run%0d busy after busy reload", r), 32'(busy_u[runs[r].unit]), 32'd1);
         wait_done(runs[r].unit, start, runs[r].cycles, runs[r].sum, $sformatf("run%0d", r));
      end

      // Reload from DONE on unit A.
      @(negedge clk);
      reload_u[0] = 1'b1;
      @(negedge clk);
      reload_u[0] = 1'b0;
      chk("reload done drops",        32'(done_u[0]),   32'd0);
      chk("reload cpu_rst_bar drops", 32'(cpurst_u[0]), 32'd0);
      start = cyc;
      wait_done(0, start, 21, 8'h14, "reload");

      // Second reload, then reset in the middle of the byte-2 write strobe.
      @(negedge clk);
      reload_u[0] = 1'b1;
      @(negedge clk);
      reload_u[0] = 1'b0;
      n = 0;
      while (!(we_u[0] === 1'b0 && ram_addr_a == 12'd2) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reached byte2 write", 32'(we_u[0] === 1'b0 && ram_addr_a == 12'd2), 32'd1);
      #1 rst_u[0] = 1'b1;
      #1;
      chk("async rst ram_we_bar",  32'(we_u[0]),     32'd1);
      chk("async rst cpu_rst_bar", 32'(cpurst_u[0]), 32'd0);
      chk("async rst checksum",    32'(csum_u[0]),   32'd0);
      chk("async rst ram_addr",    32'(ram_addr_a),  32'd0);
      repeat (2) @(negedge clk);
      rst_u[0] = 1'b0;
      start = cyc;
      wait_done(0, start, 21, 8'h14, "after rst");

      chk("write count", 32'(obs.size()), 32'd19);
      for (int i = 0; i < 19; i++) begin
         if (i < obs.size()) begin
            n_tests++;
            if (obs[i].unit != exp_wr[i].unit || obs[i].addr != exp_wr[i].addr ||
                obs[i].data !== exp_wr[i].data) begin
               n_fail++;
               $display("FAIL write%0d: got unit %0d addr 0x%0h data 0x%0h, expected unit %0d addr 0x%0h data 0x%0h",
                        i, obs[i].unit, obs[i].addr, obs[i].data,
                        exp_wr[i].unit, exp_wr[i].addr, exp_wr[i].data);
            end else begin
               $display("[TB] write%0d unit %0d addr 0x%0h data 0x%0h", i,
                        obs[i].unit, obs[i].addr, obs[i].data);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
